// File: rtl/anim_palette_pkg.sv
// anim_palette_pkg: shared types and constants for the animated colour palette.
//   anim_state_e : colour-cycling animation FSM states
//   rgb_t        : packed 8-bit-per-channel colour {r, g, b}
//   DEFAULT_PAL  : reset contents of palette 0 (16 entries, 24-bit {R,G,B})
//   LATENCY      : request-to-output latency in cycles
//                  (3 when PALETTE_FADE_EN is defined, otherwise 2)
package anim_palette_pkg;

    typedef enum logic [1:0] {
        ANIM_IDLE  = 2'd0,
        ANIM_COUNT = 2'd1,
        ANIM_STEP  = 2'd2
    } anim_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t DEFAULT_PAL [16] = '{
        24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
        24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF,
        24'h808080, 24'hC0C0C0, 24'h800000, 24'h008000,
        24'h000080, 24'h808000, 24'h008080, 24'hF0F0F0
    };

`ifdef PALETTE_FADE_EN
    localparam int LATENCY = 3;
`else
    localparam int LATENCY = 2;
`endif

endpackage

// File: rtl/palette_ram.sv
// palette_ram: NUM_PAL palettes of 2**IDX_W entries, one write port and one
// registered read port. A read and a write to the same entry on the same edge
// returns the old contents. Reset loads palette 0 from DEFAULT_PAL and clears
// all other palettes.
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   wr_en_i/addr_i/data_i : write port, address = {palette, index}
//   rd_en_i/addr_i        : read request, address = {palette, index}
//   rd_data_o             : registered read data, holds when rd_en_i is low
module palette_ram
    import anim_palette_pkg::*;
#(
    parameter int IDX_W   = 4,
    parameter int NUM_PAL = 4,
    parameter int PAL_W   = 2,
    parameter int DATA_W  = 24
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [PAL_W+IDX_W-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    input  logic [PAL_W+IDX_W-1:0]   rd_addr_i,
    output logic [DATA_W-1:0]        rd_data_o
);

    localparam int IDX_DEPTH = 2 ** IDX_W;
    localparam int DEPTH     = NUM_PAL * IDX_DEPTH;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_q[a] <= ((a < 16) && (a < IDX_DEPTH)) ? DATA_W'(DEFAULT_PAL[a[3:0]]) : '0;
            end
            rd_data_q <= '0;
        end else begin
            // Both are non-blocking, so a same-edge read sees the old word.
            if (rd_en_i) begin
                rd_data_q <= mem_q[rd_addr_i];
            end
            if (wr_en_i) begin
                mem_q[wr_addr_i] <= wr_data_i;
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/anim_color_palette.sv
// anim_color_palette: palette lookup with colour-cycling animation.
// Stage 1 remaps the pixel index through the animated cycling range and reads
// the palette RAM; stage 2 registers the colour (index 0 forced to black and
// flagged transparent). Optional macro PALETTE_FADE_EN adds a third stage that
// right-shifts each channel by fade_lvl_i.
// Ports:
//   clk_i, rst_ni               : clock, asynchronous active-low reset
//   px_valid_i/index_i/pal_sel_i: pixel lookup request
//   frame_tick_i, anim_en_i     : vertical-blank pulse, animation enable
//   anim_period_i               : frame ticks per cycling step minus one
//   cyc_lo_i, cyc_hi_i          : inclusive cycling index range
//   wr_en_i/pal_i/idx_i/rgb_i   : palette write port ({R,G,B})
//   fade_lvl_i                  : brightness shift (PALETTE_FADE_EN only)
//   red_o/green_o/blue_o        : looked-up colour
//   rgb_valid_o, transparent_o  : output valid, index-0 flag
module anim_color_palette
    import anim_palette_pkg::*;
#(
    parameter  int IDX_W   = 4,
    parameter  int NUM_PAL = 4,
    parameter  int COLOR_W = 8,
    localparam int PAL_W   = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 px_valid_i,
    input  logic [IDX_W-1:0]     px_index_i,
    input  logic [PAL_W-1:0]     pal_sel_i,
    input  logic                 frame_tick_i,
    input  logic                 anim_en_i,
    input  logic [3:0]           anim_period_i,
    input  logic [IDX_W-1:0]     cyc_lo_i,
    input  logic [IDX_W-1:0]     cyc_hi_i,
    input  logic                 wr_en_i,
    input  logic [PAL_W-1:0]     wr_pal_i,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  logic [3*COLOR_W-1:0] wr_rgb_i,
    input  logic [2:0]           fade_lvl_i,
    output logic [COLOR_W-1:0]   red_o,
    output logic [COLOR_W-1:0]   green_o,
    output logic [COLOR_W-1:0]   blue_o,
    output logic                 rgb_valid_o,
    output logic                 transparent_o
);

    localparam int LEN_W = IDX_W + 1;
    localparam int RGB_W = 3 * COLOR_W;

    anim_state_e          state_q, state_d;
    logic [3:0]           tick_cnt_q, tick_cnt_d;
    logic [IDX_W-1:0]     offset_q, offset_d;

    logic                 range_en, in_rng;
    logic [LEN_W-1:0]     rng_len, rel_sum, rel_mod;
    logic [IDX_W-1:0]     eff_idx;
    logic [PAL_W-1:0]     rd_pal;
    logic                 wr_ok;
    logic [RGB_W-1:0]     ram_rd;

    logic                 vld1_q, transp1_q;
    logic                 vld2_q, transp2_q;
    logic [RGB_W-1:0]     rgb2_q;

    // Index remap; rng_len is only meaningful when range_en is set.
    assign range_en = (cyc_lo_i <= cyc_hi_i);
    assign rng_len  = {1'b0, cyc_hi_i} - {1'b0, cyc_lo_i} + LEN_W'(1);
    assign in_rng   = range_en && (px_index_i != '0) &&
                      (px_index_i >= cyc_lo_i) && (px_index_i <= cyc_hi_i);
    assign rel_sum  = {1'b0, px_index_i - cyc_lo_i} + {1'b0, offset_q};
    assign rel_mod  = (rng_len != '0) ? (rel_sum % rng_len) : '0;
    assign eff_idx  = in_rng ? (cyc_lo_i + rel_mod[IDX_W-1:0]) : px_index_i;

    assign rd_pal = (32'(pal_sel_i) < NUM_PAL) ? pal_sel_i : '0;
    assign wr_ok  = wr_en_i && (32'(wr_pal_i) < NUM_PAL);

    // Animation FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ANIM_IDLE;
            tick_cnt_q <= '0;
            offset_q   <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            offset_q   <= offset_d;
        end
    end

    // Animation FSM: next state
    always_comb begin
        state_d = state_q;
        if (!anim_en_i) begin
            state_d = ANIM_IDLE;
        end else begin
            case (state_q)
                ANIM_IDLE:  state_d = ANIM_COUNT;
                ANIM_COUNT: if (frame_tick_i && (tick_cnt_q == anim_period_i)) state_d = ANIM_STEP;
                ANIM_STEP:  state_d = ANIM_COUNT;
                default:    state_d = ANIM_IDLE;
            endcase
        end
    end

    // Animation FSM: counter and offset updates. The offset only moves in
    // STEP, which always directly follows a frame tick.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        offset_d   = offset_q;
        if (!anim_en_i) begin
            tick_cnt_d = '0;
            offset_d   = '0;
        end else begin
            case (state_q)
                ANIM_IDLE: tick_cnt_d = '0;
                ANIM_COUNT: begin
                    if (frame_tick_i) begin
                        tick_cnt_d = (tick_cnt_q == anim_period_i) ? 4'd0 : tick_cnt_q + 4'd1;
                    end
                end
                ANIM_STEP: begin
                    offset_d = (({1'b0, offset_q} + LEN_W'(1)) >= rng_len) ? '0 : offset_q + IDX_W'(1);
                end
                default: ;
            endcase
        end
        if (!range_en) begin
            offset_d = '0;
        end
    end

    palette_ram #(
        .IDX_W   (IDX_W),
        .NUM_PAL (NUM_PAL),
        .PAL_W   (PAL_W),
        .DATA_W  (RGB_W)
    ) u_ram (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (wr_ok),
        .wr_addr_i ({wr_pal_i, wr_idx_i}),
        .wr_data_i (wr_rgb_i),
        .rd_en_i   (px_valid_i),
        .rd_addr_i ({rd_pal, eff_idx}),
        .rd_data_o (ram_rd)
    );

    // Stage 1 -> stage 2 boundary: request control alongside the RAM read
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld1_q    <= 1'b0;
            transp1_q <= 1'b0;
        end else begin
            vld1_q    <= px_valid_i;
            transp1_q <= (px_index_i == '0);
        end
    end

    // Stage 2: colour register, holds its value on bubbles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld2_q    <= 1'b0;
            transp2_q <= 1'b0;
            rgb2_q    <= '0;
        end else begin
            vld2_q <= vld1_q;
            if (vld1_q) begin
                transp2_q <= transp1_q;
                rgb2_q    <= transp1_q ? '0 : ram_rd;
            end
        end
    end

`ifdef PALETTE_FADE_EN
    logic             vld3_q, transp3_q;
    logic [RGB_W-1:0] rgb3_q;

    // Stage 3: per-channel brightness fade; black stays black
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld3_q    <= 1'b0;
            transp3_q <= 1'b0;
            rgb3_q    <= '0;
        end else begin
            vld3_q <= vld2_q;
            if (vld2_q) begin
                transp3_q <= transp2_q;
                rgb3_q    <= {rgb2_q[3*COLOR_W-1:2*COLOR_W] >> fade_lvl_i,
                              rgb2_q[2*COLOR_W-1:COLOR_W]   >> fade_lvl_i,
                              rgb2_q[COLOR_W-1:0]           >> fade_lvl_i};
            end
        end
    end

    assign rgb_valid_o   = vld3_q;
    assign transparent_o = transp3_q;
    assign red_o         = rgb3_q[3*COLOR_W-1:2*COLOR_W];
    assign green_o       = rgb3_q[2*COLOR_W-1:COLOR_W];
    assign blue_o        = rgb3_q[COLOR_W-1:0];
`else
    logic unused_fade;
    assign unused_fade = ^fade_lvl_i;

    assign rgb_valid_o   = vld2_q;
    assign transparent_o = transp2_q;
    assign red_o         = rgb2_q[3*COLOR_W-1:2*COLOR_W];
    assign green_o       = rgb2_q[2*COLOR_W-1:COLOR_W];
    assign blue_o        = rgb2_q[COLOR_W-1:0];
`endif

endmodule
